corrige_hamming_stream: RTL and testbench

//  Parametrised, pipelined Hamming decoder/corrector for a valid/ready codeword stream.
//  - Generalises the fixed (15,11) corrector to any (2^R-1, 2^R-1-R) code.
//  - Adds an output pipeline, backpressure, error status and saturating error counters.
//  - Sits between the channel/memory read path and data consumers.

---
 rtl/hamming_pkg.sv | 48 ++++
 rtl/hamming_sindrome.sv | 32 +++
 rtl/corrige_hamming_stream.sv | 162 ++++++++++++++++
 tb/tb_corrige_hamming_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared sizing, bit-map and status helpers for the parametrised Hamming stream corrector.
// Used by both builds: with and without HAMMING_SECDED_EN.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_CORR = 2'd1,
        ST_DBL  = 2'd2
    } status_e;

    function automatic int cw_width(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int data_width(input int r);
        return (1 << r) - 1 - r;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Bit i is set when 1-based position i+1 is covered by syndrome bit j.
    function automatic logic [63:0] mask(input int j, input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[i] = (i < n) && ((((i + 1) >> j) & 1) != 0);
        end
        return m;
    endfunction

    // Codeword index of the k-th data bit (non-power-of-two positions, ascending).
    function automatic int data_index(input int k);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int pos = 1; pos < 64; pos++) begin
            if (!is_pow2(pos)) begin
                if (cnt == k) res = pos - 1;
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// Combinational syndrome generator; with HAMMING_SECDED_EN it also produces the
// overall parity of the full codeword.
module hamming_sindrome
    import hamming_pkg::*;
#(
    parameter int R    = 4,
    parameter int CW_W = 15
) (
    input  logic [CW_W-1:0] entrada,
`ifdef HAMMING_SECDED_EN
    output logic            paridade,
`endif
    output logic [R-1:0]    sindrome
);

    localparam int N = cw_width(R);

    always_comb begin
        logic [63:0] m;
        m = '0;
        sindrome = '0;
        for (int j = 0; j < R; j++) begin
            m = mask(j, N);
            sindrome[j] = ^(entrada[N-1:0] & m[N-1:0]);
        end
    end

`ifdef HAMMING_SECDED_EN
    assign paridade = ^entrada;
`endif

endmodule

// File: rtl/corrige_hamming_stream.sv
// Two-stage valid/ready Hamming (2^R-1) corrector with status and saturating counters.
// Define HAMMING_SECDED_EN to add the overall parity bit and double-error detection.
module corrige_hamming_stream
    import hamming_pkg::*;
#(
    parameter int R     = 4,
    parameter int CNT_W = 16,
    localparam int N    = cw_width(R),
    localparam int K    = data_width(R),
`ifdef HAMMING_SECDED_EN
    localparam int CW_W = N + 1
`else
    localparam int CW_W = N
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW_W-1:0]  entrada,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [K-1:0]     saida,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_corr,
    output logic             err_dbl,
    output logic [R-1:0]     err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_dbl
);

    logic          adv;
    logic          xfer;
    logic [R-1:0]  syn_nxt;
    logic          s1_valid;
    logic [N-1:0]  s1_cw;
    logic [R-1:0]  s1_syn;
    logic [N-1:0]  cw_fix;
    logic [K-1:0]  data_nxt;
    logic          flip;
    status_e       st;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = out_valid && out_ready;

`ifdef HAMMING_SECDED_EN
    logic par_nxt;
    logic s1_par;

    hamming_sindrome #(.R(R), .CW_W(CW_W)) u_sindrome (
        .entrada  (entrada),
        .paridade (par_nxt),
        .sindrome (syn_nxt)
    );
`else
    hamming_sindrome #(.R(R), .CW_W(CW_W)) u_sindrome (
        .entrada  (entrada),
        .sindrome (syn_nxt)
    );
`endif

    // S1: codeword and syndrome
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
`ifdef HAMMING_SECDED_EN
            s1_par   <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= entrada[N-1:0];
                s1_syn <= syn_nxt;
`ifdef HAMMING_SECDED_EN
                s1_par <= par_nxt;
`endif
            end
        end
    end

    always_comb begin
        st   = ST_OK;
        flip = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (s1_syn != '0 && s1_par) begin
            st   = ST_CORR;
            flip = 1'b1;
        end else if (s1_syn == '0 && s1_par) begin
            st   = ST_CORR;
        end else if (s1_syn != '0) begin
            st   = ST_DBL;
        end
`else
        if (s1_syn != '0) begin
            st   = ST_CORR;
            flip = 1'b1;
        end
`endif
        cw_fix = s1_cw;
        for (int i = 0; i < N; i++) begin
            if (flip && s1_syn == R'(i + 1)) cw_fix[i] = ~s1_cw[i];
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_data
        assign data_nxt[k] = cw_fix[data_index(k)];
    end

    // S2: corrected data and status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            saida     <= '0;
            err_corr  <= 1'b0;
            err_pos   <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                saida    <= data_nxt;
                err_corr <= (st == ST_CORR);
                err_pos  <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_corr <= '0;
        end else if (cnt_clr) begin
            cnt_corr <= '0;
        end else if (xfer && err_corr && cnt_corr != '1) begin
            cnt_corr <= cnt_corr + CNT_W'(1);
        end
    end

`ifdef HAMMING_SECDED_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_dbl <= 1'b0;
        end else if (adv && s1_valid) begin
            err_dbl <= (st == ST_DBL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_dbl <= '0;
        end else if (cnt_clr) begin
            cnt_dbl <= '0;
        end else if (xfer && err_dbl && cnt_dbl != '1) begin
            cnt_dbl <= cnt_dbl + CNT_W'(1);
        end
    end
`else
    assign err_dbl = 1'b0;
    assign cnt_dbl = '0;
`endif

endmodule

// File: tb/tb_corrige_hamming_stream.sv
// Directed bench for corrige_hamming_stream (R=4, CNT_W=2); follows HAMMING_SECDED_EN.
module tb_corrige_hamming_stream;

    localparam int R     = 4;
    localparam int CNT_W = 2;
`ifdef HAMMING_SECDED_EN
    localparam int CW_W  = 16;
`else
    localparam int CW_W  = 15;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CW_W-1:0]  entrada;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      saida;
    logic             out_valid;
    logic             out_ready;
    logic             err_corr;
    logic             err_dbl;
    logic [R-1:0]     err_pos;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_dbl;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    corrige_hamming_stream #(.R(R), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entrada   (entrada),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .saida     (saida),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_corr  (err_corr),
        .err_dbl   (err_dbl),
        .err_pos   (err_pos),
        .cnt_clr   (cnt_clr),
        .cnt_corr  (cnt_corr),
        .cnt_dbl   (cnt_dbl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW_W-1:0] cw(input logic [15:0] v);
        return v[CW_W-1:0];
    endfunction

    // One word through an idle pipe: latency, decoded outputs, then the transfer.
    task automatic apply(input string tag, input logic [15:0] w, input logic [10:0] d,
                         input logic corr, input logic dbl, input logic [3:0] pos,
                         input logic clr);
        entrada   = cw(w);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(saida),     32'(d));
        check({tag, "_corr"},  32'(err_corr),  32'(corr));
        check({tag, "_dbl"},   32'(err_dbl),   32'(dbl));
        check({tag, "_pos"},   32'(err_pos),   32'(pos));
        cnt_clr = clr;
        step();
        cnt_clr = 1'b0;
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] bp_w [4];
    logic [10:0] bp_d [4];

    initial begin
        int tx, rx;
        logic stall_prev;
        logic [10:0] held;

        rst_n     = 1'b0;
        entrada   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_saida",    32'(saida),     32'd0);
        check("rst_corr",     32'(err_corr),  32'd0);
        check("rst_dbl",      32'(err_dbl),   32'd0);
        check("rst_pos",      32'(err_pos),   32'd0);
        check("rst_cnt_corr", 32'(cnt_corr),  32'd0);
        check("rst_cnt_dbl",  32'(cnt_dbl),   32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);

        apply("clean", 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0, 1'b0);
        check("clean_cnt", 32'(cnt_corr), 32'd0);

        apply("single", 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5, 1'b0);
        check("single_cnt", 32'(cnt_corr), 32'd1);

`ifdef HAMMING_SECDED_EN
        apply("double", 16'h0011, 11'h002, 1'b0, 1'b1, 4'd4, 1'b0);
        check("double_cnt_corr", 32'(cnt_corr), 32'd1);
        check("double_cnt_dbl",  32'(cnt_dbl),  32'd1);
        apply("overall", 16'h8000, 11'h000, 1'b1, 1'b0, 4'd0, 1'b0);
        check("overall_cnt", 32'(cnt_corr), 32'd2);
`else
        apply("double", 16'h0011, 11'h002, 1'b1, 1'b0, 4'd4, 1'b0);
        check("double_cnt_corr", 32'(cnt_corr), 32'd2);
        check("double_cnt_dbl",  32'(cnt_dbl),  32'd0);
`endif

        apply("pos9", 16'hC18B, 11'h400, 1'b1, 1'b0, 4'd9, 1'b0);

        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_cnt_corr", 32'(cnt_corr), 32'd0);
        check("clr_cnt_dbl",  32'(cnt_dbl),  32'd0);

        // Backpressure: four back-to-back words, consumer stalls in cycles 3-5.
        bp_w[0] = 16'h8007; bp_d[0] = 11'h001;
        bp_w[1] = 16'hC08B; bp_d[1] = 11'h400;
        bp_w[2] = 16'hFFFF; bp_d[2] = 11'h7FF;
        bp_w[3] = 16'h0000; bp_d[3] = 11'h000;
        tx = 0;
        rx = 0;
        stall_prev = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && rx < 4; c++) begin
            logic acc;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (tx < 4);
            entrada   = (tx < 4) ? cw(bp_w[tx]) : '0;
            #1;
            if (stall_prev) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data",  32'(saida),     32'(held));
            end
            if (out_valid && !out_ready) begin
                check("bp_in_ready", 32'(in_ready), 32'd0);
                held = saida;
            end
            stall_prev = out_valid && !out_ready;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check($sformatf("bp_data%0d", rx), 32'(saida), 32'(bp_d[rx]));
                rx++;
            end
            step();
            if (acc) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_sent",      32'(tx), 32'd4);
        check("bp_delivered", 32'(rx), 32'd4);
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);
        check("bp_cnt",    32'(cnt_corr),  32'd0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("sat%0d", i), 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5, 1'b0);
            check($sformatf("sat%0d_cnt", i), 32'(cnt_corr), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        apply("clr_sat", 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5, 1'b1);
        check("clr_sat_cnt", 32'(cnt_corr), 32'd0);
        apply("clr_zero", 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5, 1'b1);
        check("clr_zero_cnt", 32'(cnt_corr), 32'd0);

        // Reset with two words in flight.
        apply("pre_rst", 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5, 1'b0);
        check("pre_rst_cnt", 32'(cnt_corr), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        entrada   = cw(16'h8007);
        step();
        entrada   = cw(16'hC08B);
        step();
        in_valid = 1'b0;
        check("rst_mid_inflight", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_cnt",   32'(cnt_corr),  32'd0);
        step();
        check("rst_mid_no_partial", 32'(out_valid), 32'd0);
        apply("post_rst", 16'h8007, 11'h001, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
